// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the generic pipeline stage register.
//   stage_state_t : occupancy state of a stage (main register / skid register).
//   DEF_DATA_W    : default data payload width.
//   DEF_CTRL_W    : default control payload width.
package pipe_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // nothing held
    S_ONE   = 2'd1,  // main register holds an entry
    S_TWO   = 2'd2   // main and skid registers both hold an entry
  } stage_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: one valid/ready link between two pipeline stages.
//
// Handshake semantics: the master raises valid with data/ctrl stable and keeps
// them stable until the cycle in which ready is also high; the entry transfers
// on the rising clock edge where valid && ready. Ready may be high with no
// valid entry offered, and nothing transfers in a cycle where either is low.
//
//   valid : master -> slave, entry offered
//   ready : slave -> master, entry can be taken
//   data  : master -> slave, data payload
//   ctrl  : master -> slave, control payload
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   reset : synchronous active-high clear (the only way back to zero)
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic pipeline stage register with a one-entry skid
// buffer, so the upstream ready is a register output rather than a function
// of the downstream ready.
//   clk, reset : clock (rising edge) and synchronous active-high reset
//   flush      : drop every held entry and any entry accepted this cycle
//   up         : upstream link (slave side); up.ready is registered
//   dn         : downstream link (master side); all outputs registered
//   occupancy  : number of held entries, 0..2
//   stall_cnt  : saturating count of cycles with dn.valid && !dn.ready
//   state      : current occupancy state, exposed for debug
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int CTRL_W         = DEF_CTRL_W,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_skid_if.slave       up,
  pipe_stage_skid_if.master      dn,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output stage_state_t           state
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  stage_state_t      nxt_state;
  logic              nxt_main_valid, nxt_skid_valid;
  logic [DATA_W-1:0] nxt_main_data, nxt_skid_data;
  logic [CTRL_W-1:0] nxt_main_ctrl, nxt_skid_ctrl;
  logic [1:0]        nxt_occupancy;
  logic              accept, drain;

  assign up.ready  = (state != S_TWO);
  assign dn.valid  = main_valid;
  assign dn.data   = main_data;
  assign dn.ctrl   = main_ctrl;

  assign accept = up.valid && up.ready;
  assign drain  = main_valid && dn.ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_EMPTY;
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      occupancy  <= 2'd0;
    end else begin
      state      <= nxt_state;
      main_valid <= nxt_main_valid;
      main_data  <= nxt_main_data;
      main_ctrl  <= nxt_main_ctrl;
      skid_valid <= nxt_skid_valid;
      skid_data  <= nxt_skid_data;
      skid_ctrl  <= nxt_skid_ctrl;
      occupancy  <= nxt_occupancy;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_main_valid = main_valid;
    nxt_main_data  = main_data;
    nxt_main_ctrl  = main_ctrl;
    nxt_skid_valid = skid_valid;
    nxt_skid_data  = skid_data;
    nxt_skid_ctrl  = skid_ctrl;

    if (flush) begin
      // A drain in this cycle has already completed downstream; only the
      // held entries and the incoming one are dropped. Ctrl is always zeroed
      // so the bubble is control-neutral.
      nxt_state      = S_EMPTY;
      nxt_main_valid = 1'b0;
      nxt_main_ctrl  = '0;
      nxt_skid_valid = 1'b0;
      nxt_skid_ctrl  = '0;
      if (CLEAR_ON_FLUSH) begin
        nxt_main_data = '0;
        nxt_skid_data = '0;
      end
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            nxt_main_valid = 1'b1;
            nxt_main_data  = up.data;
            nxt_main_ctrl  = up.ctrl;
            nxt_state      = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            nxt_main_data = up.data;
            nxt_main_ctrl = up.ctrl;
          end else if (drain) begin
            // Data is left in place; only valid and ctrl form the bubble.
            nxt_main_valid = 1'b0;
            nxt_main_ctrl  = '0;
            nxt_state      = S_EMPTY;
          end else if (accept) begin
            // Younger entry parks in the skid; output stays on main.
            nxt_skid_valid = 1'b1;
            nxt_skid_data  = up.data;
            nxt_skid_ctrl  = up.ctrl;
            nxt_state      = S_TWO;
          end
        end
        S_TWO: begin
          if (drain) begin
            nxt_main_data  = skid_data;
            nxt_main_ctrl  = skid_ctrl;
            nxt_skid_valid = 1'b0;
            nxt_skid_data  = '0;
            nxt_skid_ctrl  = '0;
            nxt_state      = S_ONE;
          end
        end
        default: begin
          nxt_state      = S_EMPTY;
          nxt_main_valid = 1'b0;
          nxt_main_ctrl  = '0;
          nxt_skid_valid = 1'b0;
          nxt_skid_ctrl  = '0;
        end
      endcase
    end

    nxt_occupancy = {1'b0, nxt_main_valid} + {1'b0, nxt_skid_valid};
  end

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_valid && !dn.ready),
    .count (stall_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field EX_MEM/ID_EX stage registers: one generic pipeline stage register with a valid/ready handshake in both directions.
- Holds a data payload and a control payload, with a one-entry skid buffer so upstream ready is registered.
- Supports a flush that inserts a bubble, optional payload clearing on flush, and a saturating stall-cycle counter for performance debug.
- Instantiated between every pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) in the next core revision.

Parameters:
- DATA_W, 32, data payload width (operands, ALU result, ...).
- CTRL_W, 8, control payload width (MemtoReg, RegSrc, MemWrite, InstrType, ...).
- CLEAR_ON_FLUSH, 1, when 1 the data payload is zeroed on flush; when 0 the data payload is held. The control payload is always zeroed on flush.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, synchronous, active-high reset.
- flush, input, 1, discard all held entries and any entry being accepted this cycle.
- in_valid, input, 1, upstream offers an entry.
- in_ready, output, 1, stage can accept an entry; registered, equals !skid_valid.
- in_data, input, DATA_W, upstream data payload.
- in_ctrl, input, CTRL_W, upstream control payload.
- out_valid, output, 1, main entry valid.
- out_ready, input, 1, downstream accepts the entry.
- out_data, output, DATA_W, main data payload.
- out_ctrl, output, CTRL_W, main control payload.
- occupancy, output, 2, held entries (0..2).
- stall_cnt, output, STALL_CNT_W, cycles with out_valid && !out_ready, saturating.

Behaviour:
- Handshakes:
  - Accept = in_valid && in_ready.
  - Drain = out_valid && out_ready.
  - All updates happen on the rising clk edge.
- Reset (sync, highest priority): the clocked state resets to:
  - state=S_EMPTY
  - out_valid=0, out_data=0, out_ctrl=0
  - skid contents=0
  - occupancy=0
  - stall_cnt=0
- in_ready = (state != S_TWO). It reads 1 out of reset, and while reset is held. Accepts offered while reset is high are ignored.
- States (main/skid occupancy):
  - S_EMPTY: accept -> main loaded, S_ONE.
  - S_ONE, accept && drain: main <= in, stay S_ONE.
  - S_ONE, drain only: main cleared (valid=0, ctrl=0), S_EMPTY.
  - S_ONE, accept only: skid <= in, S_TWO.
  - S_ONE, neither: hold.
  - S_TWO: in_ready=0, so no accept. Drain -> main <= skid, skid cleared, S_ONE. No drain -> hold.
- Ordering is strictly FIFO: the skid always holds the younger entry, and output is always taken from main.
- Latency is 1 cycle from accept to out_valid when the stage is empty. There are no combinational paths from in_* to out_* or from out_ready to in_ready.
- Flush (below reset, above everything else):
  - Next state is S_EMPTY, and out_valid, skid valid and out_ctrl are zeroed.
  - If CLEAR_ON_FLUSH=1, out_data is zeroed; otherwise out_data holds.
  - An accept in the flush cycle is discarded.
  - A drain in the flush cycle still counts as completed downstream; flush does not retract it.
- Flush and reset together: reset wins; the result is identical in either case.
- out_ctrl=0 whenever out_valid=0. This makes bubbles control-neutral.
- stall_cnt increments when out_valid && !out_ready. It saturates at all-ones and no wrap is allowed. Only reset clears it; flush does not.
- occupancy = main_valid + skid_valid, registered, consistent with the state.

Decomposition:
- pipe_pkg holds:
  - typedef enum logic [1:0] stage_state_t {S_EMPTY, S_ONE, S_TWO}.
  - Localparam defaults for DATA_W and CTRL_W.
- One sub-module: sat_counter (parameter W; ports clk, reset, inc, count), used for stall_cnt.

Test Plan:
- Reset then stream: hold reset 1 cycle, then in_valid=1 with in_data=10, 20, 30 on consecutive cycles and out_ready=1 -> out_data 10, 20, 30 one cycle later each. occupancy=1 throughout and stall_cnt=0.
- Backpressure and skid: accept data=5, then out_ready=0 while offering data=6 -> occupancy=2 and in_ready=0. Offer data=7 (held off). Raise out_ready -> out_data sequence 5, 6, 7 with no loss or duplication; stall_cnt=1 (one cycle with out_valid=1 and out_ready=0).
- Flush mid-operation: with occupancy=2 (data 5, 6), assert flush together with in_valid=1 and data=9 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. With CLEAR_ON_FLUSH=1, out_data=0. Data 9 is never emitted.
- Reset mid-operation: with occupancy=2 and stall_cnt=3, assert reset together with flush=1 -> all outputs 0, including stall_cnt, and in_ready=1.
- Saturation: STALL_CNT_W=2, out_valid held with out_ready=0 for 6 cycles -> stall_cnt sequence 1, 2, 3, 3, 3, 3.
- CLEAR_ON_FLUSH=0: flush with out_data=0xDEAD -> out_data stays 0xDEAD while out_valid=0 and out_ctrl=0.
